// File: rtl/mig_tt_engine_pkg.sv
// Shared types and helpers for the MIG truth-table engine: operand encoding,
// controller states, projection words and derived-width functions.
package mig_tt_pkg;

    localparam int unsigned MAX_NUM_IN = 6;
    localparam int unsigned MAX_TT_W   = 64;
    localparam int unsigned MAX_IDX_W  = 6;

    typedef struct packed {
        logic                 neg;
        logic [MAX_IDX_W-1:0] idx;
    } operand_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic int unsigned idx_width(input int unsigned num_in, input int unsigned max_gates);
        return $clog2(1 + num_in + max_gates);
    endfunction

    function automatic int unsigned gi_width(input int unsigned max_gates);
        return (max_gates > 1) ? $clog2(max_gates) : 1;
    endfunction

    // Bit m of input xi is bit i of the minterm index m.
    function automatic logic [MAX_TT_W-1:0] proj_tt(input int unsigned i);
        logic [MAX_TT_W-1:0] w;
        w = '0;
        for (int unsigned m = 0; m < MAX_TT_W; m++) begin
            w[m] = m[i];
        end
        return w;
    endfunction

endpackage

// File: rtl/mig_tt_engine_maj_lane.sv
// Bit-parallel majority lane: each operand word is optionally inverted,
// then every bit position takes the majority of the three.
module mig_maj_lane #(
    parameter int unsigned TT_W = 16
) (
    input  logic [TT_W-1:0] a,
    input  logic [TT_W-1:0] b,
    input  logic [TT_W-1:0] c,
    input  logic            neg_a,
    input  logic            neg_b,
    input  logic            neg_c,
    output logic [TT_W-1:0] y
);

    logic [TT_W-1:0] va;
    logic [TT_W-1:0] vb;
    logic [TT_W-1:0] vc;

    always_comb begin
        va = a ^ {TT_W{neg_a}};
        vb = b ^ {TT_W{neg_b}};
        vc = c ^ {TT_W{neg_c}};
        y  = (va & vb) | (va & vc) | (vb & vc);
    end

endmodule

// File: rtl/mig_tt_engine.sv
// Sequential MIG evaluator: one majority gate per cycle over full truth-table words.
// Optional self-check ports (expect_tt, match) exist only when MIG_TT_CHECK_EN is defined.
module mig_tt_engine
    import mig_tt_pkg::*;
#(
    parameter  int unsigned NUM_IN    = 4,
    parameter  int unsigned MAX_GATES = 8,
    localparam int unsigned TT_W      = 1 << NUM_IN,
    localparam int unsigned IDX_W     = idx_width(NUM_IN, MAX_GATES),
    localparam int unsigned OP_W      = IDX_W + 1,
    localparam int unsigned GI_W      = gi_width(MAX_GATES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_valid,
    output logic              prog_ready,
    input  logic [GI_W-1:0]   prog_idx,
    input  logic [3*OP_W-1:0] prog_gate,
    input  logic [GI_W:0]     num_gates,
    input  logic [OP_W-1:0]   out_sel,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [TT_W-1:0]   tt,
    output logic              err
`ifdef MIG_TT_CHECK_EN
    ,
    input  logic [TT_W-1:0]   expect_tt,
    output logic              match
`endif
);

    state_t            state;
    logic [GI_W-1:0]   g_cnt;
    logic [GI_W:0]     n_reg;
    logic [OP_W-1:0]   sel_reg;
    logic [3*OP_W-1:0] prog_mem [MAX_GATES];
    logic [TT_W-1:0]   node_w   [MAX_GATES];

    logic [3*OP_W-1:0] cur_gate;
    operand_t          op_a, op_b, op_c, sel_op;
    logic [TT_W-1:0]   w_a, w_b, w_c, sel_w, maj_y, fin_tt;
    logic              bad_a, bad_b, bad_c, gate_bad, sel_bad;

`ifdef MIG_TT_CHECK_EN
    logic [TT_W-1:0]   exp_reg;
`endif

    function automatic operand_t to_operand(input logic [OP_W-1:0] raw);
        operand_t o;
        o.neg = raw[OP_W-1];
        o.idx = MAX_IDX_W'(raw[IDX_W-1:0]);
        return o;
    endfunction

    // Gates at or beyond 'limit' are not yet valid for this reader: they read as 0 and flag an error.
    function automatic logic [TT_W-1:0] fetch(input operand_t op, input int unsigned limit,
                                              output logic bad);
        logic [TT_W-1:0] w;
        int unsigned     idx;
        int unsigned     j;
        idx = 32'(op.idx);
        bad = 1'b0;
        w   = '0;
        if (idx >= 1 && idx <= NUM_IN) begin
            w = TT_W'(proj_tt(idx - 1));
        end else if (idx > NUM_IN) begin
            j = idx - NUM_IN - 1;
            if (j < limit) begin
                w = node_w[GI_W'(j)];
            end else begin
                bad = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb begin
        cur_gate = prog_mem[g_cnt];
        op_a     = to_operand(cur_gate[OP_W-1:0]);
        op_b     = to_operand(cur_gate[2*OP_W-1:OP_W]);
        op_c     = to_operand(cur_gate[3*OP_W-1:2*OP_W]);
        w_a      = fetch(op_a, 32'(g_cnt), bad_a);
        w_b      = fetch(op_b, 32'(g_cnt), bad_b);
        w_c      = fetch(op_c, 32'(g_cnt), bad_c);
        gate_bad = bad_a | bad_b | bad_c;
        sel_op   = to_operand(sel_reg);
        sel_w    = fetch(sel_op, 32'(n_reg), sel_bad);
        fin_tt   = sel_w ^ {TT_W{sel_op.neg}};
    end

    mig_maj_lane #(
        .TT_W (TT_W)
    ) u_lane (
        .a     (w_a),
        .b     (w_b),
        .c     (w_c),
        .neg_a (op_a.neg),
        .neg_b (op_b.neg),
        .neg_c (op_c.neg),
        .y     (maj_y)
    );

    assign prog_ready = (state == IDLE);
    assign busy       = (state == EVAL) || (state == FIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            g_cnt   <= '0;
            n_reg   <= '0;
            sel_reg <= '0;
            done    <= 1'b0;
            tt      <= '0;
            err     <= 1'b0;
            for (int unsigned i = 0; i < MAX_GATES; i++) begin
                prog_mem[i] <= '0;
                node_w[i]   <= '0;
            end
`ifdef MIG_TT_CHECK_EN
            exp_reg <= '0;
            match   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            // The write lands at the same edge start is taken, so gate 0 already sees it.
            if (prog_valid && state == IDLE && 32'(prog_idx) < MAX_GATES) begin
                prog_mem[prog_idx] <= prog_gate;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_reg <= out_sel;
                        g_cnt   <= '0;
                        if (32'(num_gates) > MAX_GATES) begin
                            n_reg <= (GI_W+1)'(MAX_GATES);
                            err   <= 1'b1;
                        end else begin
                            n_reg <= num_gates;
                            err   <= 1'b0;
                        end
                        state <= (num_gates == '0) ? FIN : EVAL;
`ifdef MIG_TT_CHECK_EN
                        exp_reg <= expect_tt;
`endif
                    end
                end
                EVAL: begin
                    node_w[g_cnt] <= maj_y;
                    if (gate_bad) begin
                        err <= 1'b1;
                    end
                    if (32'(g_cnt) + 1 >= 32'(n_reg)) begin
                        state <= FIN;
                    end else begin
                        g_cnt <= g_cnt + GI_W'(1);
                    end
                end
                FIN: begin
                    tt    <= fin_tt;
                    err   <= err | sel_bad;
                    done  <= 1'b1;
                    state <= IDLE;
`ifdef MIG_TT_CHECK_EN
                    match <= (fin_tt == exp_reg) && !(err | sel_bad);
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mig_tt_engine.sv
// Scoreboard bench for mig_tt_engine: directed scenarios plus random programs
// checked against a per-minterm reference model.
module tb_mig_tt_engine;

    localparam int unsigned NI   = 4;
    localparam int unsigned MG   = 8;
    localparam int unsigned TTW  = 16;
    localparam int unsigned OPW  = 5;
    localparam int unsigned GIW  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              prog_valid = 1'b0;
    logic              prog_ready;
    logic [GIW-1:0]    prog_idx = '0;
    logic [3*OPW-1:0]  prog_gate = '0;
    logic [GIW:0]      num_gates = '0;
    logic [OPW-1:0]    out_sel = '0;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic [TTW-1:0]    tt;
    logic              err;
`ifdef MIG_TT_CHECK_EN
    logic [TTW-1:0]    expect_tt = '0;
    logic              match;
`endif

    mig_tt_engine #(
        .NUM_IN    (NI),
        .MAX_GATES (MG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_valid (prog_valid),
        .prog_ready (prog_ready),
        .prog_idx   (prog_idx),
        .prog_gate  (prog_gate),
        .num_gates  (num_gates),
        .out_sel    (out_sel),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .tt         (tt),
        .err        (err)
`ifdef MIG_TT_CHECK_EN
        ,
        .expect_tt  (expect_tt),
        .match      (match)
`endif
    );

    always #5 clk = ~clk;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [TTW-1:0] tt;
        logic           err;
        logic           match;
        int unsigned    due;
    } exp_t;

    exp_t           sb[$];
    int             checks = 0;
    int             passes = 0;
    logic [3*OPW-1:0] pm [MG];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, edge_cnt);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got done=1, expected no pulse (edge %0d)", edge_cnt);
            end else begin
                e = sb.pop_front();
                chk("tt", 64'(tt), 64'(e.tt));
                chk("err", 64'(err), 64'(e.err));
                chk("latency", 64'(edge_cnt), 64'(e.due));
`ifdef MIG_TT_CHECK_EN
                chk("match", 64'(match), 64'(e.match));
`endif
            end
        end
    end

    function automatic logic [OPW-1:0] op(input logic neg, input int unsigned idx);
        logic [3:0] i4;
        i4 = idx[3:0];
        return {neg, i4};
    endfunction

    function automatic logic [3*OPW-1:0] gate(input logic [OPW-1:0] c, input logic [OPW-1:0] b,
                                              input logic [OPW-1:0] a);
        return {c, b, a};
    endfunction

    // Node value for one minterm; gates at or beyond lim are not yet computed.
    function automatic bit rd(input int unsigned idx, input int unsigned lim, input int unsigned m,
                              input bit gv [MG], inout bit e);
        int unsigned j;
        if (idx == 0) return 1'b0;
        if (idx <= NI) return m[idx-1];
        j = idx - NI - 1;
        if (j < lim) return gv[j];
        e = 1'b1;
        return 1'b0;
    endfunction

    function automatic void model(input int unsigned n_req, input logic [OPW-1:0] sel,
                                  output logic [TTW-1:0] ett, output logic eerr);
        int unsigned    n;
        bit             e;
        bit             gv [MG];
        logic [3*OPW-1:0] g;
        logic [OPW-1:0] o;
        int unsigned    sum;
        e = (n_req > MG);
        n = (n_req > MG) ? MG : n_req;
        ett = '0;
        for (int unsigned m = 0; m < TTW; m++) begin
            for (int unsigned k = 0; k < MG; k++) gv[k] = 1'b0;
            for (int unsigned gi = 0; gi < n; gi++) begin
                g = pm[gi];
                sum = 0;
                for (int unsigned k = 0; k < 3; k++) begin
                    o = g[k*OPW +: OPW];
                    sum += 32'(rd(32'(o[3:0]), gi, m, gv, e) ^ o[4]);
                end
                gv[gi] = (sum >= 2);
            end
            ett[m] = rd(32'(sel[3:0]), n, m, gv, e) ^ sel[4];
        end
        eerr = e;
    endfunction

    task automatic write_gate(input int unsigned slot, input logic [3*OPW-1:0] g);
        prog_valid = 1'b1;
        prog_idx   = slot[GIW-1:0];
        prog_gate  = g;
        @(posedge clk); #1;
        prog_valid = 1'b0;
        pm[slot]   = g;
    endtask

    task automatic run_exp(input int unsigned n, input logic [OPW-1:0] sel, input logic [TTW-1:0] et,
                           input logic [TTW-1:0] tt_req, input logic err_req);
        exp_t e;
        int unsigned nn;
        nn = (n > MG) ? MG : n;
        num_gates = n[GIW:0];
        out_sel   = sel;
`ifdef MIG_TT_CHECK_EN
        expect_tt = et;
`endif
        e.tt    = tt_req;
        e.err   = err_req;
        e.match = (tt_req == et) && !err_req;
        e.due   = edge_cnt + nn + 2;
        sb.push_back(e);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_model(input int unsigned n, input logic [OPW-1:0] sel, input bit exact_exp);
        logic [TTW-1:0] mt;
        logic           me;
        logic [TTW-1:0] et;
        model(n, sel, mt, me);
        et = exact_exp ? mt : TTW'($urandom);
        run_exp(n, sel, et, mt, me);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL done_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [OPW-1:0] rop();
        int unsigned idx;
        idx = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, NI + MG);
        return op(1'($urandom_range(0, 1)), idx);
    endfunction

    initial begin
        for (int i = 0; i < MG; i++) pm[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_tt", 64'(tt), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_ready", 64'(prog_ready), 64'h1);

        // Basic majority, plain and inverted output.
        write_gate(0, gate(op(0, 3), op(0, 2), op(0, 1)));
        run_exp(1, op(0, 5), 16'hE8E8, 16'hE8E8, 1'b0); drain();
        run_exp(1, op(1, 5), 16'hE8E9, 16'h1717, 1'b0); drain();

        // OR / AND via constants.
        write_gate(0, gate(op(1, 0), op(0, 3), op(0, 2)));
        write_gate(1, gate(op(0, 0), op(0, 4), op(0, 1)));
        run_exp(2, op(0, 6), 16'hAA00, 16'hAA00, 1'b0); drain();
        run_exp(2, op(0, 5), 16'h0, 16'hFCFC, 1'b0); drain();

        // n=0 and saturation.
        run_exp(0, op(0, 4), 16'hFF00, 16'hFF00, 1'b0); drain();
        run_exp(9, op(0, 6), 16'h0, 16'hAA00, 1'b1); drain();
        run_exp(15, op(0, 4), 16'h0, 16'hFF00, 1'b1); drain();

        // Self reference, out_sel beyond n, out-of-range index, then recovery.
        write_gate(0, gate(op(0, 5), op(0, 2), op(0, 1)));
        run_exp(1, op(0, 5), 16'h0, 16'h8888, 1'b1); drain();
        run_exp(1, op(0, 6), 16'h0, 16'h0, 1'b1); drain();
        run_exp(0, op(0, 13), 16'h0, 16'h0, 1'b1); drain();
        write_gate(0, gate(op(0, 3), op(0, 2), op(0, 1)));
        run_exp(1, op(0, 5), 16'hE8E8, 16'hE8E8, 1'b0); drain();

        // Simultaneous write and start: evaluation sees the new slot.
        prog_valid = 1'b1; prog_idx = '0; prog_gate = gate(op(1, 0), op(0, 2), op(0, 1));
        pm[0] = prog_gate;
        run_exp(1, op(0, 5), 16'h0, 16'hEEEE, 1'b0);
        prog_valid = 1'b0;
        drain();

        // Start and write while busy are ignored.
        write_gate(0, gate(op(0, 3), op(0, 2), op(0, 1)));
        write_gate(2, gate(op(0, 3), op(0, 6), op(0, 5)));
        run_model(3, op(0, 7), 1'b1);
        chk("busy_in_eval", 64'(busy), 64'h1);
        chk("ready_in_eval", 64'(prog_ready), 64'h0);
        start = 1'b1; num_gates = '0; out_sel = op(0, 1);
        prog_valid = 1'b1; prog_idx = '0; prog_gate = gate(op(1, 0), op(1, 0), op(1, 0));
        @(posedge clk); #1;
        start = 1'b0; prog_valid = 1'b0;
        drain();
        repeat (4) @(posedge clk); #1;
        run_exp(1, op(0, 5), 16'h0, 16'hE8E8, 1'b0); drain();

        // Reset mid-run aborts and clears the program.
        run_exp(3, op(0, 7), 16'h0, 16'h0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < MG; i++) pm[i] = '0;
        repeat (6) @(posedge clk); #1;
        chk("abort_tt", 64'(tt), 64'h0);
        chk("abort_err", 64'(err), 64'h0);
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_ready", 64'(prog_ready), 64'h1);
        run_exp(1, op(0, 5), 16'h0, 16'h0, 1'b0); drain();

        // Random programs against the reference model.
        for (int it = 0; it < 40; it++) begin
            int unsigned nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < int'(nw); w++) begin
                write_gate($urandom_range(0, MG - 1), gate(rop(), rop(), rop()));
            end
            run_model($urandom_range(0, 10), rop(), 1'($urandom_range(0, 1)));
            drain();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mig_tt_engine.md
# mig_tt_engine

Programmable, sequential majority-inverter-graph evaluator. It computes the full truth table of a stored MIG over NUM_IN inputs, one majority gate per clock cycle, using bit-parallel 2^NUM_IN-wide node words. It generalises the fixed 4-input exact-synthesis MIG netlists to runtime-loaded programs. Exact-synthesis results are checked against expected truth tables in simulation and on FPGA.

## Interface
- NUM_IN, 4: number of primary inputs, legal 2..6; TT_W = 2**NUM_IN is derived, not overridable.
- MAX_GATES, 8: gate program depth, legal 1..32.
- Derived: IDX_W = $clog2(1+NUM_IN+MAX_GATES); OP_W = IDX_W+1 ({neg, idx}); GI_W = $clog2(MAX_GATES).

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- prog_valid  in  1  gate write request.
- prog_ready  out  1  high only in IDLE.
- prog_idx  in  GI_W  gate slot written.
- prog_gate  in  3*OP_W  operands {c,b,a}, each {neg, idx}.
- num_gates  in  GI_W+1  gates to evaluate, sampled at start.
- out_sel  in  OP_W  output node {neg, idx}, sampled at start.
- start  in  1  begin evaluation; accepted only in IDLE.
- busy  out  1  high in EVAL and FIN.
- done  out  1  one-cycle pulse, tt valid.
- tt  out  TT_W  result truth table, bit m = f(input vector m).
- err  out  1  program error flag, valid with done.

## Operation
- Node numbering: 0 = constant 0; 1..NUM_IN = x0..x{NUM_IN-1}; NUM_IN+1+g = gate g.
- Input words are projections: tt bit m of xi = bit i of m (NUM_IN=4: x0 0xAAAA, x1 0xCCCC, x2 0xF0F0, x3 0xFF00).
- Operand value = node word XOR {TT_W{neg}}. Gate = bitwise MAJ(a,b,c). AND/OR are expressed as MAJ with constant 0 / ~0.
- States: IDLE -> EVAL on start (num_gates>0), IDLE -> FIN on start (num_gates==0), EVAL -> FIN after the last gate, FIN -> IDLE.
- Program write: prog_valid && prog_ready stores prog_gate in slot prog_idx in the same cycle. Writes in other states are not accepted.
- EVAL evaluates gate g = 0..n-1, one per cycle, and writes node NUM_IN+1+g.
- Forward or self reference (operand gate index >= g), or idx beyond the last node, reads as 0 and sets sticky err.
- num_gates > MAX_GATES: n saturates to MAX_GATES and err is set.
- out_sel referring to a gate >= n reads as 0 and sets err.
- FIN: tt <= out_sel operand value, done = 1.
- start while busy is ignored. Simultaneous start and prog_valid in IDLE: the write is performed and start is accepted. The evaluation uses the new entry.

## Timing
- start sampled at edge k. Gate g is evaluated in cycle k+1+g. done is high in cycle k+n+1, and tt/err update at that edge. Latency = n+1 cycles; n=0 gives 1 cycle.
- tt and err hold until the next done. err clears when start is accepted.
- Reset values: state IDLE, prog_ready 1, busy 0, done 0, tt 0, err 0, all gate slots {0,0,0} (evaluates to 0), node words 0.
- rst during EVAL or FIN aborts immediately: no done pulse, and the program is cleared.

## Configuration
- MIG_TT_CHECK_EN defined: adds input expect_tt [TT_W] (sampled at start) and output match [1] (registered, updated with done, = (tt == expect_tt) && !err, reset 0).
- MIG_TT_CHECK_EN undefined: those ports and their logic are absent. All other behaviour is identical.

## Structure
- Package mig_tt_pkg holds:
  - operand typedef {neg, idx};
  - state enum {IDLE, EVAL, FIN};
  - function proj_tt(i) returning the projection word;
  - width helper functions.
- Sub-module mig_maj_lane: combinational, three operand words plus three neg bits -> TT_W majority word; one instance.
- Node words are held in registers, not RAM, so that every node is readable in the same cycle.

## Test plan
- NUM_IN=4: gate0 = MAJ(x0,x1,x2), n=1, out_sel gate0 -> done at k+2, tt=0xE8E8, err=0. With out_sel neg=1: tt=0x1717.
- Two gates: g0 = MAJ(x1,x2,~0) (0xFCFC), g1 = MAJ(x0,x3,0) (0xAA00), out_sel g1 -> tt=0xAA00 at k+3.
- n=0, out_sel x3 -> done at k+1, tt=0xFF00. n=MAX_GATES+1 -> err=1.
- g0 operand referencing gate 0 (self) -> err=1, tt computed with the operand read as 0. The next valid run clears err.
- rst asserted at k+1 of a 3-gate run -> no done, outputs at reset values. The next start with an unprogrammed slot gives tt=0.
- MIG_TT_CHECK_EN: expect_tt=0xE8E8 on the first scenario -> match=1; expect_tt=0xE8E9 -> match=0. start asserted while busy is ignored; exactly one done pulse.
